// File: rtl/echo_pkg.sv
// Shared types, default widths and the saturating mix helper for the echo controller.
package echo_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 10;
  localparam int GAIN_W_DEF     = 4;
  localparam int GAIN_SHIFT_DEF = 4;
  localparam int MID            = 2 ** (DATA_W_DEF - 1);

  typedef enum logic [2:0] {INIT, CLEAR, IDLE, READ, WRITE} state_t;

  // Clamp a signed mix to the sample range and return it in offset binary.
  function automatic int sat_mix(input int m, input int data_w);
    int half;
    int c;
    half = 1 << (data_w - 1);
    if (m > half - 1)   c = half - 1;
    else if (m < -half) c = -half;
    else                c = m;
    return c + half;
  endfunction

endpackage

// File: rtl/echo_mix.sv
// Combinational echo mixer: input sample plus gain-scaled delayed sample, saturated.
module echo_mix
  import echo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_W     = GAIN_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
  input  logic [DATA_W-1:0] sample_q,
  input  logic [DATA_W-1:0] del_q,
  input  logic [GAIN_W-1:0] gain_q,
  output logic [DATA_W-1:0] mix
);

  localparam int M_W = DATA_W + GAIN_W + 1;
  localparam logic signed [M_W-1:0] MID_W = M_W'(2 ** (DATA_W - 1));

  logic signed [M_W-1:0] s_in;
  logic signed [M_W-1:0] s_del;
  logic signed [M_W-1:0] g_s;
  logic signed [M_W-1:0] prod;
  logic signed [M_W-1:0] m;

  always_comb begin
    s_in  = $signed(M_W'(sample_q)) - MID_W;
    s_del = $signed(M_W'(del_q)) - MID_W;
    g_s   = $signed(M_W'(gain_q));
    prod  = s_del * g_s;
    // Arithmetic shift rounds toward -inf, matching the intended floor scaling.
    m     = s_in + (prod >>> GAIN_SHIFT);
    mix   = DATA_W'(sat_mix(int'(m), DATA_W));
  end

endmodule

// File: rtl/echo_ctrl.sv
// Circular-buffer controller for the echo RAM: clear after reset, then read-delayed /
// mix / write-back for every accepted sample.
module echo_ctrl
  import echo_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_W     = GAIN_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] delay,
  input  logic [GAIN_W-1:0] gain,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              overrun,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [DATA_W-1:0] MID_V  = DATA_W'(2 ** (DATA_W - 1));
  localparam logic [ADDR_W-1:0] LAST_A = '1;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   wr_ptr, clr_cnt, delay_q;
  logic [DATA_W-1:0]   sample_q, del_q, mix;
  logic [GAIN_W-1:0]   gain_q;

  echo_mix #(
    .DATA_W     (DATA_W),
    .GAIN_W     (GAIN_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_mix (
    .sample_q (sample_q),
    .del_q    (del_q),
    .gain_q   (gain_q),
    .mix      (mix)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nx;
  end

  // Outputs decode the registered state, so mem_we falls the instant reset_n asserts.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx = state;
    ready    = 1'b0;
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = MID_V;
    unique case (state)
      INIT:  state_nx = CLEAR_EN ? CLEAR : IDLE;
      CLEAR: begin
        mem_we = 1'b1;
        mem_a  = clr_cnt;
        if (clr_cnt == LAST_A) state_nx = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (sample_valid) state_nx = READ;
      end
      READ: begin
        mem_a    = wr_ptr - delay_q;
        state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_a    = wr_ptr;
        mem_wd   = mix;
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  // NOTE: the sample RAM itself has no reset; the CLEAR pass scrubs it to midscale instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      clr_cnt    <= '0;
      delay_q    <= '0;
      gain_q     <= '0;
      sample_q   <= MID_V;
      del_q      <= MID_V;
      out_sample <= MID_V;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= (state == WRITE);
      if (sample_valid && !ready) overrun <= 1'b1;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
      if (sample_valid && ready) begin
        sample_q <= sample_in;
        delay_q  <= delay;
        gain_q   <= gain;
      end
      if (state == READ) del_q <= mem_rd;
      if (state == WRITE) begin
        out_sample <= mix;
        wr_ptr     <= wr_ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_echo_ctrl.sv
// Self-checking bench for echo_ctrl: RAM model, queue-based echo model, directed vectors.
module tb_echo_ctrl;
  import echo_pkg::*;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [9:0]  sample_in = '0;
  logic [12:0] delay = '0;
  logic [3:0]  gain = '0;
  logic        ready, out_valid, overrun, mem_we;
  logic [9:0]  out_sample, mem_wd, mem_rd;
  logic [12:0] mem_a;
  logic [9:0]  ram [DEPTH];

  always #5 clk = ~clk;

  echo_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .delay        (delay),
    .gain         (gain),
    .ready        (ready),
    .out_valid    (out_valid),
    .out_sample   (out_sample),
    .overrun      (overrun),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = ram[mem_a];

  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic check(input string name, input int act, input int expv);
    check_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // RAM behaviour plus write monitor (clear address sequence, last write address).
  int cyc = 0;
  int we_cnt = 0, addr_err = 0, clr_exp = 0, last_wa = -1;
  bit clr_phase = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (mem_we) begin
      ram[mem_a] = mem_wd;
      if (clr_phase && int'(mem_a) != clr_exp) addr_err++;
      clr_exp++;
      we_cnt++;
      last_wa = int'(mem_a);
    end
  end

  // Echo model: the buffer is a plain array indexed by sample count modulo depth.
  typedef struct { int cyc; int val; } exp_t;
  int   mram [DEPTH];
  int   mn;
  exp_t exp_q[$];
  int   mlog[$], obs[$], acc[$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mram[i] = MID;
    mn = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int x, input int d, input int g);
    int rd, p, m, mix;
    exp_t e;
    rd = mram[(mn - d) & (DEPTH - 1)];
    p  = (rd - MID) * g;
    m  = (x - MID) + (p >>> 4);
    if (m > MID - 1) m = MID - 1;
    if (m < -MID)    m = -MID;
    mix = m + MID;
    mram[mn & (DEPTH - 1)] = mix;
    mn++;
    e.cyc = cyc + 3;
    e.val = mix;
    exp_q.push_back(e);
    mlog.push_back(mix);
    acc.push_back(cyc);
  endtask

  // Every-cycle compare of the output strobe and sample against the model.
  bit due;
  always @(negedge clk) begin
    if (reset_n) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (out_valid || due) begin
        check("out_valid", int'(out_valid), int'(due));
        if (due) begin
          check("out_sample", int'(out_sample), exp_q[0].val);
          obs.push_back(int'(out_sample));
          exp_q.pop_front();
        end
      end
    end
  end

  task automatic send(input int x, input int d, input int g);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) check("ready_timeout", 0, 1);
    model_accept(x, d, g);
    sample_valid = 1'b1;
    sample_in    = 10'(x);
    delay        = 13'(d);
    gain         = 4'(g);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
  endtask

  // Release reset at a falling edge and verify the full clear pass.
  task automatic release_and_clear(input string tag);
    int n, bad;
    @(negedge clk);
    clr_phase = 1'b1;
    clr_exp   = 0;
    we_cnt    = 0;
    addr_err  = 0;
    reset_n   = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    clr_phase = 1'b0;
    check({tag, "_ready_cycles"}, n, 1 + DEPTH);
    check({tag, "_clear_writes"}, we_cnt, DEPTH);
    check({tag, "_clear_addr_errs"}, addr_err, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 10'd512) bad++;
    check({tag, "_ram_not_mid"}, bad, 0);
    model_reset();
  endtask

  initial begin
    int lit3 [9];
    int bad;
    lit3 = '{612, 512, 512, 512, 562, 512, 512, 512, 537};
    for (int i = 0; i < DEPTH; i++) ram[i] = 10'h155;
    model_reset();

    // T1: reset values, then clear pass
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_sample", int'(out_sample), 512);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_a", int'(mem_a), 0);
    check("rst_mem_wd", int'(mem_wd), 512);
    release_and_clear("t1");

    // T2: unity path, back-to-back throughput
    obs.delete(); acc.delete();
    send(100, 5, 0); send(200, 5, 0); send(300, 5, 0);
    drain();
    check("t2_count", obs.size(), 3);
    check("t2_out0", obs[0], 100);
    check("t2_out1", obs[1], 200);
    check("t2_out2", obs[2], 300);
    check("t2_gap01", acc[1] - acc[0], 3);
    check("t2_gap12", acc[2] - acc[1], 3);

    // T3: decaying echo, delay 4, gain 8/16 (history flushed to midscale first)
    for (int i = 0; i < 4; i++) send(512, 4, 0);
    drain();
    obs.delete(); mlog.delete();
    for (int i = 0; i < 9; i++) send((i == 0) ? 612 : 512, 4, 8);
    drain();
    for (int i = 0; i < 9; i++) check($sformatf("t3_out%0d", i), obs[i], lit3[i]);
    check("t3_model4", mlog[4], 562);
    check("t3_model8", mlog[8], 537);

    // T4: saturation at both rails
    obs.delete();
    send(1023, 1, 0); send(1023, 1, 15); send(1023, 1, 15);
    send(0, 1, 0);    send(0, 1, 15);    send(0, 1, 15);
    drain();
    check("t4_hi1", obs[1], 1023);
    check("t4_hi2", obs[2], 1023);
    check("t4_lo1", obs[4], 0);
    check("t4_lo2", obs[5], 0);

    // T5: strobe while busy is dropped and flagged
    check("t5_overrun_pre", int'(overrun), 0);
    acc.delete();
    send(300, 2, 4);
    sample_valid = 1'b1;
    sample_in    = 10'd999;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    check("t5_overrun_set", int'(overrun), 1);
    send(400, 2, 4);
    drain();
    check("t5_overrun_sticky", int'(overrun), 1);
    check("t5_gap", acc[1] - acc[0], 3);

    // T6: pointer wrap with mixed-sign feedback, then reset during WRITE
    for (int i = 0; i < 8195; i++) send((i * 37 + 11) % 1024, 3, 5);
    drain();
    check("t6_last_addr", last_wa, (mn - 1) & (DEPTH - 1));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(ram[i]) != mram[i]) bad++;
    check("t6_ram_vs_model", bad, 0);
    send(700, 3, 5);
    @(posedge clk);
    #1 check("t6_in_write", int'(mem_we), 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1 check("t6_async_we", int'(mem_we), 0);
    @(negedge clk);
    check("t6_rst_ready", int'(ready), 0);
    check("t6_rst_overrun", int'(overrun), 0);
    check("t6_rst_out_valid", int'(out_valid), 0);
    release_and_clear("t6");
    obs.delete();
    send(600, 1, 8);
    drain();
    check("t6_ptr_restart", last_wa, 0);
    check("t6_first_out", obs[0], 600);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
